// File: rtl/ibuf_credit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ibuf_credit_ctrl_pkg
//   Shared types and helpers for the instruction-buffer credit controller.
//   - IBUF_CREDIT_W      : counter width for a per-warp in-flight count
//   - ibuf_drain_state_t : per-warp drain FSM states (IDLE, DRAIN, DONE)
//   - wis_to_wid()       : maps (warp-in-slot, issue slot) to a warp id
//   Build-time defaults for `IBUF_SIZE and `PERF_CTR_BITS are provided here
//   when the surrounding build has not defined them.
// ---------------------------------------------------------------------------
`ifndef IBUF_SIZE
`define IBUF_SIZE 2
`endif

`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 16
`endif

package ibuf_credit_ctrl_pkg;

    localparam int IBUF_CREDIT_W = $clog2(`IBUF_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ibuf_drain_state_t;

    // Warps are striped across issue slots: slot isw owns warps isw,
    // isw+issue_width, isw+2*issue_width, ...
    function automatic int wis_to_wid(input int wis, input int isw, input int issue_width);
        return wis * issue_width + isw;
    endfunction

endpackage

// File: rtl/ibuf_credit_warp.sv
// ---------------------------------------------------------------------------
// ibuf_credit_warp
//   One warp's in-flight instruction counter plus its drain FSM.
//   Ports:
//     clk, reset   : clock, asynchronous active-high reset
//     inc          : qualified allocation for this warp (already gated by credit_ok)
//     dec          : an ibuffer pop of this warp this cycle
//     drain_req    : request to drain this warp (ignored unless IDLE)
//     count        : registered in-flight count
//     state        : registered drain FSM state (also serves as debug view)
//     credit_ok    : warp may accept another allocation this cycle
//     underflow    : pop seen while count is zero and no same-cycle alloc
// ---------------------------------------------------------------------------
import ibuf_credit_ctrl_pkg::*;

module ibuf_credit_warp #(
    parameter  int CREDITS = `IBUF_SIZE,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              drain_req,
    output logic [CNT_W-1:0]  count,
    output ibuf_drain_state_t state,
    output logic              credit_ok,
    output logic              underflow
);

    logic [CNT_W-1:0]  count_next;
    ibuf_drain_state_t state_next;

    // Alloc and pop together net to zero, even at count 0.
    always_comb begin
        count_next = count;
        underflow  = 1'b0;
        if (inc && !dec) begin
            count_next = count + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count == '0) begin
                underflow = 1'b1;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    // DRAIN looks at the registered count, so a warp that is already empty
    // reaches DONE on its first DRAIN cycle (two cycles after the request).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drain_req) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            state <= IDLE;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

    // Registered-only: no same-cycle path from alloc or pop.
    assign credit_ok = (count < CNT_W'(CREDITS)) && (state == IDLE);

endmodule

// File: rtl/ibuf_credit_ctrl.sv
// ---------------------------------------------------------------------------
// ibuf_credit_ctrl
//   Per-warp credit controller between the warp scheduler and the ibuffer.
//   Tracks in-flight instructions per warp, exports a may-fetch mask and
//   runs a per-warp drain handshake for warp control.
//   Ports:
//     clk, reset       : clock, asynchronous active-high reset
//     alloc_valid/wid  : one fetch dispatched this cycle, and its warp
//     pop_valid/wis    : per issue slot ibuffer pop and its warp-in-slot
//     drain_req        : per-warp one-cycle drain request
//     drain_done       : per-warp one-cycle "drained" pulse
//     warp_credit_ok   : per-warp may-allocate mask
//     idle             : every warp count is zero
//     err_overflow     : sticky, alloc to a warp without credit
//     err_underflow    : sticky, pop of a warp with zero count
//     perf_full_cycles : (IBUF_CREDIT_PERF_EN only) cycles with no warp
//                        allocatable while work is in flight; wraps
//   Optional feature macro: IBUF_CREDIT_PERF_EN
// ---------------------------------------------------------------------------
import ibuf_credit_ctrl_pkg::*;

module ibuf_credit_ctrl #(
    parameter  int CORE_ID     = 0,
    parameter  int NUM_WARPS   = 4,
    parameter  int ISSUE_WIDTH = 2,
    parameter  int CREDITS     = `IBUF_SIZE,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int ISSUE_WIS_W = ((NUM_WARPS / ISSUE_WIDTH) > 1) ? $clog2(NUM_WARPS / ISSUE_WIDTH) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc_valid,
    input  logic [NW_WIDTH-1:0]                alloc_wid,
    input  logic [ISSUE_WIDTH-1:0]             pop_valid,
    input  logic [ISSUE_WIDTH*ISSUE_WIS_W-1:0] pop_wis,
    input  logic [NUM_WARPS-1:0]               drain_req,
    output logic [NUM_WARPS-1:0]               drain_done,
    output logic [NUM_WARPS-1:0]               warp_credit_ok,
    output logic                               idle,
    output logic                               err_overflow,
    output logic                               err_underflow
`ifdef IBUF_CREDIT_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0]          perf_full_cycles
`endif
);

    localparam int CNT_W = $clog2(CREDITS + 1);

    if (CREDITS < 1) begin : g_bad_credits
        $error("ibuf_credit_ctrl core %0d: CREDITS must be >= 1", CORE_ID);
    end

    logic [NUM_WARPS-1:0] alloc_hit;
    logic [NUM_WARPS-1:0] inc;
    logic [NUM_WARPS-1:0] dec;
    logic [NUM_WARPS-1:0] underflow_w;
    logic [CNT_W-1:0]     count [NUM_WARPS];
    ibuf_drain_state_t    warp_state [NUM_WARPS];
    logic                 overflow_evt;

    // Handshake meaning: alloc_valid and each pop_valid bit are already
    // completed transfers (the scheduler/ibuffer applied their own ready),
    // so every asserted bit is counted in the cycle it is seen. An alloc is
    // honoured only when warp_credit_ok for that warp was 1 in that cycle.
    always_comb begin
        alloc_hit = '0;
        dec       = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            alloc_hit[w] = alloc_valid && (alloc_wid == NW_WIDTH'(w));
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (pop_valid[i]
                    && wis_to_wid(int'(pop_wis[i*ISSUE_WIS_W +: ISSUE_WIS_W]), i, ISSUE_WIDTH) == w) begin
                    dec[w] = 1'b1;
                end
            end
        end
    end

    assign inc          = alloc_hit & warp_credit_ok;
    assign overflow_evt = alloc_valid && (inc == '0);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        ibuf_credit_warp #(
            .CREDITS (CREDITS)
        ) u_warp (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[w]),
            .dec       (dec[w]),
            .drain_req (drain_req[w]),
            .count     (count[w]),
            .state     (warp_state[w]),
            .credit_ok (warp_credit_ok[w]),
            .underflow (underflow_w[w])
        );
        assign drain_done[w] = (warp_state[w] == DONE);
    end

    always_comb begin
        idle = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (count[w] != '0) idle = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= err_overflow | overflow_evt;
            err_underflow <= err_underflow | (|underflow_w);
        end
    end

`ifdef IBUF_CREDIT_PERF_EN
    // Counts backpressure cycles only: a fully drained core (idle) whose
    // warps are all blocked by drains is not "full".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_full_cycles <= '0;
        end else if ((warp_credit_ok == '0) && !idle) begin
            perf_full_cycles <= perf_full_cycles + `PERF_CTR_BITS'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ibuf_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibuf_credit_ctrl
//   Directed plus randomized bench for ibuf_credit_ctrl with NUM_WARPS=4,
//   ISSUE_WIDTH=2, CREDITS=2. A behavioural model (per-warp integer counts
//   and drain flags) predicts every output; a compare process checks the
//   DUT against it on every falling edge outside reset, and directed steps
//   pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_ibuf_credit_ctrl;

    localparam int NW = 4;
    localparam int IW = 2;
    localparam int CR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_valid = 1'b0;
    logic [1:0] alloc_wid = '0;
    logic [1:0] pop_valid = '0;
    logic [1:0] pop_wis = '0;
    logic [3:0] drain_req = '0;
    logic [3:0] drain_done;
    logic [3:0] warp_credit_ok;
    logic       idle;
    logic       err_overflow;
    logic       err_underflow;
`ifdef IBUF_CREDIT_PERF_EN
    logic [`PERF_CTR_BITS-1:0] perf_full_cycles;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ibuf_credit_ctrl #(
        .CORE_ID     (0),
        .NUM_WARPS   (NW),
        .ISSUE_WIDTH (IW),
        .CREDITS     (CR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_wid      (alloc_wid),
        .pop_valid      (pop_valid),
        .pop_wis        (pop_wis),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .warp_credit_ok (warp_credit_ok),
        .idle           (idle),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
`ifdef IBUF_CREDIT_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_count [NW] = '{0, 0, 0, 0};
    bit m_drain [NW] = '{0, 0, 0, 0};
    bit m_done  [NW] = '{0, 0, 0, 0};
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    logic [63:0] m_perf = '0;

    function automatic logic [3:0] exp_ok();
        logic [3:0] r;
        for (int w = 0; w < NW; w++) r[w] = (m_count[w] < CR) && !m_drain[w] && !m_done[w];
        return r;
    endfunction

    function automatic logic exp_idle();
        int total;
        total = 0;
        for (int w = 0; w < NW; w++) total += m_count[w];
        return (total == 0);
    endfunction

    function automatic logic [3:0] exp_done();
        logic [3:0] r;
        for (int w = 0; w < NW; w++) r[w] = m_done[w];
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [3:0] ok_now;
        bit inc, dec;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                m_count[w] = 0;
                m_drain[w] = 0;
                m_done[w]  = 0;
            end
            m_ovf  = 0;
            m_unf  = 0;
            m_perf = '0;
        end else begin
            ok_now = exp_ok();
            if (ok_now == 4'b0000 && !exp_idle()) m_perf = m_perf + 64'd1;
            if (alloc_valid && !ok_now[alloc_wid]) m_ovf = 1;
            for (int w = 0; w < NW; w++) begin
                inc = alloc_valid && (int'(alloc_wid) == w) && ok_now[w];
                dec = 0;
                for (int s = 0; s < IW; s++) begin
                    if (pop_valid[s] && (int'(pop_wis[s]) * IW + s) == w) dec = 1;
                end
                // drain progress uses the count before this edge's update
                if (m_done[w]) begin
                    m_done[w] = 0;
                end else if (m_drain[w]) begin
                    if (m_count[w] == 0) begin
                        m_drain[w] = 0;
                        m_done[w]  = 1;
                    end
                end else if (drain_req[w]) begin
                    m_drain[w] = 1;
                end
                if (inc && !dec) m_count[w] = m_count[w] + 1;
                else if (dec && !inc) begin
                    if (m_count[w] == 0) m_unf = 1;
                    else m_count[w] = m_count[w] - 1;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("cmp_credit_ok", 64'(warp_credit_ok), 64'(exp_ok()));
            check("cmp_idle", 64'(idle), 64'(exp_idle()));
            check("cmp_drain_done", 64'(drain_done), 64'(exp_done()));
            check("cmp_err_overflow", 64'(err_overflow), 64'(m_ovf));
            check("cmp_err_underflow", 64'(err_underflow), 64'(m_unf));
`ifdef IBUF_CREDIT_PERF_EN
            check("cmp_perf", 64'(perf_full_cycles), 64'(m_perf[`PERF_CTR_BITS-1:0]));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic av, input logic [1:0] aw, input logic [1:0] pv,
                        input logic [1:0] pw, input logic [3:0] dr);
        alloc_valid = av;
        alloc_wid   = aw;
        pop_valid   = pv;
        pop_wis     = pw;
        drain_req   = dr;
        @(posedge clk);
        #2;
        alloc_valid = 1'b0;
        alloc_wid   = '0;
        pop_valid   = '0;
        pop_wis     = '0;
        drain_req   = '0;
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 2'b00, 2'b00, 4'b0000);
    endtask

    task automatic alloc(input int w);
        step(1'b1, 2'(w), 2'b00, 2'b00, 4'b0000);
    endtask

    // wid w lives in slot w%2 with warp-in-slot w/2
    task automatic pop_wid(input int w);
        logic [1:0] pv;
        logic [1:0] pw;
        pv = '0;
        pw = '0;
        pv[w % 2] = 1'b1;
        pw[w % 2] = 1'(w / 2);
        step(1'b0, 2'd0, pv, pw, 4'b0000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       av;
        logic [1:0] aw, pv, pw;
        logic [3:0] dr;
        int         w;

        do_reset();
        check("rst_credit_ok", 64'(warp_credit_ok), 64'h0f);
        check("rst_idle", 64'(idle), 64'h1);
        check("rst_drain_done", 64'(drain_done), 64'h0);
        check("rst_err_overflow", 64'(err_overflow), 64'h0);
        check("rst_err_underflow", 64'(err_underflow), 64'h0);
        cmp_en = 1'b1;

        // fill warp 1 to its credit limit, then overflow it
        alloc(1);
        alloc(1);
        check("full_w1_ok", 64'(warp_credit_ok), 64'hd);
        check("full_w1_idle", 64'(idle), 64'h0);
        alloc(1);
        check("ovf_flag", 64'(err_overflow), 64'h1);
        check("ovf_dropped_ok", 64'(warp_credit_ok), 64'hd);

        // same-cycle alloc+pop of warp 3 nets zero
        alloc(3);
        step(1'b1, 2'd3, 2'b10, 2'b10, 4'b0000);
        check("net0_ok", 64'(warp_credit_ok), 64'hd);
        check("net0_no_unf", 64'(err_underflow), 64'h0);
        alloc(3);
        check("net0_count_was1", 64'(warp_credit_ok), 64'h5);
        pop_wid(3);
        pop_wid(3);
        pop_wid(1);

        // two slots pop different warps in one cycle
        alloc(0);
        step(1'b0, 2'd0, 2'b11, 2'b00, 4'b0000);
        check("dual_pop_idle", 64'(idle), 64'h1);
        check("dual_pop_ok", 64'(warp_credit_ok), 64'hf);
        check("dual_pop_no_unf", 64'(err_underflow), 64'h0);

        // drain warp 2 from count 2
        alloc(2);
        alloc(2);
        step(1'b0, 2'd0, 2'b00, 2'b00, 4'b0100);
        check("drain2_blocked", 64'(warp_credit_ok), 64'hb);
        pop_wid(2);
        check("drain2_cnt1_done", 64'(drain_done), 64'h0);
        pop_wid(2);
        check("drain2_cnt0_done", 64'(drain_done), 64'h0);
        idle_step();
        check("drain2_pulse", 64'(drain_done), 64'h4);
        check("drain2_pulse_ok", 64'(warp_credit_ok), 64'hb);
        idle_step();
        check("drain2_after", 64'(drain_done), 64'h0);
        check("drain2_ok_back", 64'(warp_credit_ok), 64'hf);

        // drain of an empty warp: minimum latency 2
        step(1'b0, 2'd0, 2'b00, 2'b00, 4'b0001);
        check("drain0_lat1", 64'(drain_done), 64'h0);
        check("drain0_blocked", 64'(warp_credit_ok), 64'he);
        idle_step();
        check("drain0_lat2", 64'(drain_done), 64'h1);
        idle_step();
        check("drain0_end", 64'(drain_done), 64'h0);
        pop_wid(0);
        check("unf_flag", 64'(err_underflow), 64'h1);

        // asynchronous reset in the middle of a drain
        alloc(1);
        step(1'b0, 2'd0, 2'b00, 2'b00, 4'b0010);
        idle_step();
        #1 reset = 1'b1;
        #1;
        check("arst_ok", 64'(warp_credit_ok), 64'hf);
        check("arst_idle", 64'(idle), 64'h1);
        check("arst_done", 64'(drain_done), 64'h0);
        check("arst_ovf", 64'(err_overflow), 64'h0);
        check("arst_unf", 64'(err_underflow), 64'h0);
        repeat (3) begin
            @(negedge clk);
            check("arst_no_pulse", 64'(drain_done), 64'h0);
        end
        @(posedge clk);
        #2 reset = 1'b0;

        // fill every warp, then hold full
        for (int i = 0; i < NW; i++) begin
            alloc(i);
            alloc(i);
        end
        check("all_full_ok", 64'(warp_credit_ok), 64'h0);
`ifdef IBUF_CREDIT_PERF_EN
        check("perf_start", 64'(perf_full_cycles), 64'h0);
`endif
        repeat (5) idle_step();
`ifdef IBUF_CREDIT_PERF_EN
        check("perf_five", 64'(perf_full_cycles), 64'h5);
`endif

        // randomized traffic, mostly legal
        do_reset();
        for (int n = 0; n < 800; n++) begin
            aw = 2'($urandom_range(0, 3));
            av = (exp_ok()[aw]) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 4);
            pv = '0;
            pw = '0;
            for (int s = 0; s < IW; s++) begin
                pw[s] = 1'($urandom_range(0, 1));
                w = int'(pw[s]) * IW + s;
                pv[s] = (m_count[w] > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
            end
            dr = '0;
            for (int d = 0; d < NW; d++) dr[d] = ($urandom_range(0, 15) == 0);
            step(av, aw, pv, pw, dr);
        end

        idle_step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
